val2_shift_unit: RTL and testbench

VAL2_SHIFT_UNIT -- requirements
Module: val2_shift_unit

---
 rtl/val2_shift_unit.sv | 195 +++++++++++++++++++
 tb/tb_val2_shift_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/val2_shift_unit.sv
// ARM data-processing operand-2 shifter: decodes the shifter operand at accept,
// then shifts/rotates up to STEP bits per cycle and holds the result until consumed.
module val2_shift_unit #(
  parameter int STEP   = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_rw,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_rs,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("val2_shift_unit: DATA_W must be 32");
  end
  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32))
  begin : g_bad_step
    $error("val2_shift_unit: STEP must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} shop_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t              r_state;
  state_t              w_next_state;
  shop_t               r_op;
  shop_t               w_acc_op;
  logic [DATA_W-1:0]   r_val;
  logic                r_carry;
  logic [5:0]          r_rem;

  logic [DATA_W-1:0]   w_acc_val;
  logic                w_acc_carry;
  logic [5:0]          w_acc_eff;
  logic [4:0]          w_imm_amt;
  logic [7:0]          w_rs_amt;
  logic                w_accept;
  logic [5:0]          w_n;
  logic [DATA_W-1:0]   w_step_val;
  logic                w_step_carry;
  logic                w_unused_rs;

  assign w_imm_amt   = shift_operand[11:7];
  assign w_rs_amt    = val_rs[7:0];
  assign w_unused_rs = ^val_rs[DATA_W-1:8];
  assign w_accept    = in_valid & in_ready;
  assign w_n         = (r_rem < STEP_W) ? r_rem : STEP_W;

  // Accept-time decode: starting value, carry, operation and effective bit count.
  always_comb begin
    w_acc_val   = val_rm;
    w_acc_carry = carry_in;
    w_acc_eff   = '0;
    w_acc_op    = OP_ROR;
    if (mem_rw) begin
      w_acc_val = {20'h0, shift_operand};
    end else if (imm) begin
      w_acc_val = {24'h0, shift_operand[7:0]};
      w_acc_eff = {1'b0, shift_operand[11:8], 1'b0};
    end else if (!shift_operand[4]) begin
      case (shift_operand[6:5])
        2'b00: begin
          w_acc_op  = OP_LSL;
          w_acc_eff = {1'b0, w_imm_amt};
        end
        2'b01: begin
          w_acc_op  = OP_LSR;
          w_acc_eff = (w_imm_amt == 5'd0) ? 6'd32 : {1'b0, w_imm_amt};
        end
        2'b10: begin
          w_acc_op  = OP_ASR;
          w_acc_eff = (w_imm_amt == 5'd0) ? 6'd32 : {1'b0, w_imm_amt};
        end
        default: begin
          w_acc_op  = (w_imm_amt == 5'd0) ? OP_RRX : OP_ROR;
          w_acc_eff = (w_imm_amt == 5'd0) ? 6'd1 : {1'b0, w_imm_amt};
        end
      endcase
    end else begin
      case (shift_operand[6:5])
        2'b00: begin
          w_acc_op  = OP_LSL;
          w_acc_eff = (w_rs_amt > 8'd33) ? 6'd33 : w_rs_amt[5:0];
        end
        2'b01: begin
          w_acc_op  = OP_LSR;
          w_acc_eff = (w_rs_amt > 8'd33) ? 6'd33 : w_rs_amt[5:0];
        end
        2'b10: begin
          w_acc_op  = OP_ASR;
          w_acc_eff = (w_rs_amt > 8'd32) ? 6'd32 : w_rs_amt[5:0];
        end
        default: begin
          w_acc_op  = OP_ROR;
          w_acc_eff = {1'b0, w_rs_amt[4:0]};
          // A non-zero multiple of 32 rotates back to Rm; carry is its MSB.
          if (w_rs_amt[4:0] == 5'd0 && w_rs_amt != 8'd0) w_acc_carry = val_rm[31];
        end
      endcase
    end
  end

  // NOTE: blocking assignments inside always_comb are intentional here -- each
  // loop iteration must see the previous iteration's value, unlike the <= used for state.
  always_comb begin
    w_step_val   = r_val;
    w_step_carry = r_carry;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(w_n)) begin
        case (r_op)
          OP_LSL: begin
            w_step_carry = w_step_val[31];
            w_step_val   = {w_step_val[30:0], 1'b0};
          end
          OP_LSR: begin
            w_step_carry = w_step_val[0];
            w_step_val   = {1'b0, w_step_val[31:1]};
          end
          OP_ASR: begin
            w_step_carry = w_step_val[0];
            w_step_val   = {w_step_val[31], w_step_val[31:1]};
          end
          OP_ROR: begin
            w_step_carry = w_step_val[0];
            w_step_val   = {w_step_val[0], w_step_val[31:1]};
          end
          default: begin
            w_step_carry = w_step_val[0];
            w_step_val   = {r_carry, w_step_val[31:1]};
          end
        endcase
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid & ~rst) w_next_state = (w_acc_eff == 6'd0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (r_rem <= STEP_W) w_next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: only a handful of control/datapath flops exist, so all are reset
  // explicitly; there is no memory array whose reset would be costly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_carry <= 1'b0;
      r_rem   <= '0;
      r_op    <= OP_LSL;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_val   <= w_acc_val;
        r_carry <= w_acc_carry;
        r_rem   <= w_acc_eff;
        r_op    <= w_acc_op;
      end else if (r_state == S_SHIFT) begin
        r_val   <= w_step_val;
        r_carry <= w_step_carry;
        r_rem   <= r_rem - w_n;
      end
    end
  end

  assign val2      = r_val;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_val2_shift_unit.sv
// Self-checking bench: three shifter instances (STEP 1, 4, 32) driven in lockstep
// and compared against an arithmetic model of the ARM operand-2 rules.
module tb_val2_shift_unit;

  typedef struct {
    logic [31:0] v;
    logic        c;
    int          eff;
  } res_t;

  localparam int STEPS [3] = '{1, 4, 32};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        mem_rw;
  logic        imm;
  logic [11:0] shift_operand;
  logic [31:0] val_rm;
  logic [31:0] val_rs;
  logic        carry_in;
  logic        out_ready;

  logic        in_ready  [3];
  logic        out_valid [3];
  logic        carry_out [3];
  logic [31:0] val2      [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  val2_shift_unit #(.STEP(1)) u_step1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .mem_rw(mem_rw), .imm(imm), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .val2(val2[0]), .carry_out(carry_out[0])
  );

  val2_shift_unit #(.STEP(4)) u_step4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .mem_rw(mem_rw), .imm(imm), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .val2(val2[1]), .carry_out(carry_out[1])
  );

  val2_shift_unit #(.STEP(32)) u_step32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .mem_rw(mem_rw), .imm(imm), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .val2(val2[2]), .carry_out(carry_out[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int a);
    if (a == 0) return x;
    return (x >> a) | (x << (32 - a));
  endfunction

  // ARM operand-2 semantics in plain arithmetic; eff is the bit count the unit walks.
  function automatic res_t ref_model(input bit m, input bit im, input logic [11:0] op,
                                     input logic [31:0] rm, input logic [31:0] rs,
                                     input bit cin);
    res_t        r;
    int          a;
    logic [63:0] w;
    r.v   = rm;
    r.c   = cin;
    r.eff = 0;
    if (m) begin
      r.v = {20'h0, op};
    end else if (im) begin
      a     = 2 * int'(op[11:8]);
      r.v   = ror32({24'h0, op[7:0]}, a);
      if (a != 0) r.c = r.v[31];
      r.eff = a;
    end else begin
      a = op[4] ? int'(rs[7:0]) : int'(op[11:7]);
      if (!op[4]) begin
        if (a == 0 && op[6:5] == 2'b11) begin
          r.v   = {cin, rm[31:1]};
          r.c   = rm[0];
          r.eff = 1;
          return r;
        end
        if (a == 0 && op[6:5] != 2'b00) a = 32;
      end
      if (a != 0) begin
        case (op[6:5])
          2'b00: begin
            r.eff = (a > 33) ? 33 : a;
            if (a > 32) begin r.v = '0; r.c = 1'b0; end
            else begin w = {32'h0, rm} << a; r.v = w[31:0]; r.c = w[32]; end
          end
          2'b01: begin
            r.eff = (a > 33) ? 33 : a;
            if (a > 32) begin r.v = '0; r.c = 1'b0; end
            else begin w = {rm, 32'h0} >> a; r.v = w[63:32]; r.c = w[31]; end
          end
          2'b10: begin
            r.eff = (a > 32) ? 32 : a;
            w     = $signed({rm, 32'h0}) >>> r.eff;
            r.v   = w[63:32];
            r.c   = w[31];
          end
          default: begin
            r.eff = a % 32;
            r.v   = ror32(rm, a % 32);
            r.c   = r.v[31];
          end
        endcase
      end
    end
    return r;
  endfunction

  task automatic run_txn(input string tag, input bit m, input bit im, input logic [11:0] op,
                         input logic [31:0] rm, input logic [31:0] rs, input bit cin,
                         input res_t exp, input int hold);
    bit seen [3];
    int nseen;
    int exp_lat;
    for (int k = 0; k < 3; k++) begin
      seen[k] = 1'b0;
      check($sformatf("%s/s%0d ready_at_start", tag, STEPS[k]), 32'(in_ready[k]), 32'd1);
    end
    mem_rw = m; imm = im; shift_operand = op; val_rm = rm; val_rs = rs; carry_in = cin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    mem_rw = 1'($urandom); imm = 1'($urandom); shift_operand = 12'($urandom);
    val_rm = $urandom; val_rs = $urandom; carry_in = 1'($urandom);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s/s%0d busy_not_ready", tag, STEPS[k]), 32'(in_ready[k]), 32'd0);
    nseen = 0;
    for (int t = 1; t <= 40 && nseen < 3; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && out_valid[k]) begin
          seen[k] = 1'b1;
          nseen++;
          exp_lat = (exp.eff + STEPS[k] - 1) / STEPS[k] + 1;
          check($sformatf("%s/s%0d latency", tag, STEPS[k]), 32'(t), 32'(exp_lat));
          check($sformatf("%s/s%0d val2", tag, STEPS[k]), val2[k], exp.v);
          check($sformatf("%s/s%0d carry", tag, STEPS[k]), 32'(carry_out[k]), 32'(exp.c));
        end
      end
      if (nseen < 3) step();
    end
    for (int k = 0; k < 3; k++)
      if (!seen[k]) check($sformatf("%s/s%0d timeout", tag, STEPS[k]), 32'd0, 32'd1);
    for (int h = 0; h < hold; h++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("%s/s%0d hold_valid", tag, STEPS[k]), 32'(out_valid[k]), 32'd1);
        check($sformatf("%s/s%0d hold_val2", tag, STEPS[k]), val2[k], exp.v);
        check($sformatf("%s/s%0d hold_carry", tag, STEPS[k]), 32'(carry_out[k]), 32'(exp.c));
        check($sformatf("%s/s%0d hold_ready", tag, STEPS[k]), 32'(in_ready[k]), 32'd0);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s/s%0d consumed_valid", tag, STEPS[k]), 32'(out_valid[k]), 32'd0);
      check($sformatf("%s/s%0d consumed_ready", tag, STEPS[k]), 32'(in_ready[k]), 32'd1);
    end
  endtask

  initial begin
    res_t        exp;
    logic [31:0] rs;
    logic [11:0] op;
    logic [31:0] rm;
    bit          m;
    bit          im;
    bit          cin;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mem_rw = 1'b0; imm = 1'b0; shift_operand = '0; val_rm = '0; val_rs = '0; carry_in = 1'b0;
    step(); step(); step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset/s%0d in_ready", STEPS[k]), 32'(in_ready[k]), 32'd0);
      check($sformatf("reset/s%0d out_valid", STEPS[k]), 32'(out_valid[k]), 32'd0);
      check($sformatf("reset/s%0d val2", STEPS[k]), val2[k], 32'd0);
      check($sformatf("reset/s%0d carry", STEPS[k]), 32'(carry_out[k]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("release/s%0d in_ready", STEPS[k]), 32'(in_ready[k]), 32'd1);

    run_txn("imm_2ff", 1'b0, 1'b1, 12'h2FF, 32'h1234_5678, 32'h0, 1'b0,
            '{v: 32'hF000_000F, c: 1'b1, eff: 4}, 0);
    run_txn("lsr_imm0", 1'b0, 1'b0, 12'h020, 32'h8000_0001, 32'h0, 1'b0,
            '{v: 32'h0, c: 1'b1, eff: 32}, 0);
    run_txn("rrx", 1'b0, 1'b0, 12'h060, 32'h0000_0002, 32'h0, 1'b1,
            '{v: 32'h8000_0001, c: 1'b0, eff: 1}, 0);
    run_txn("lsl_rs33", 1'b0, 1'b0, 12'h010, 32'hFFFF_FFFF, 32'd33, 1'b1,
            '{v: 32'h0, c: 1'b0, eff: 33}, 0);
    run_txn("lsl_rs32", 1'b0, 1'b0, 12'h010, 32'h0000_0001, 32'd32, 1'b0,
            '{v: 32'h0, c: 1'b1, eff: 32}, 0);
    run_txn("ror_rs40", 1'b0, 1'b0, 12'h070, 32'h8000_0000, 32'h40, 1'b0,
            '{v: 32'h8000_0000, c: 1'b1, eff: 0}, 0);
    run_txn("asr_rs200", 1'b0, 1'b0, 12'h050, 32'h8000_0000, 32'd200, 1'b0,
            '{v: 32'hFFFF_FFFF, c: 1'b1, eff: 32}, 0);
    run_txn("mem_abc", 1'b1, 1'b1, 12'hABC, 32'hDEAD_BEEF, 32'h0, 1'b1,
            '{v: 32'h0000_0ABC, c: 1'b1, eff: 0}, 5);

    // Reset in the middle of a long shift must abort it cleanly.
    mem_rw = 1'b0; imm = 1'b0; shift_operand = 12'h020; val_rm = 32'h8000_0001;
    val_rs = '0; carry_in = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst/s%0d out_valid", STEPS[k]), 32'(out_valid[k]), 32'd0);
      check($sformatf("midrst/s%0d val2", STEPS[k]), val2[k], 32'd0);
      check($sformatf("midrst/s%0d in_ready", STEPS[k]), 32'(in_ready[k]), 32'd1);
    end
    run_txn("post_rst", 1'b0, 1'b0, 12'h020, 32'h8000_0001, 32'h0, 1'b0,
            '{v: 32'h0, c: 1'b1, eff: 32}, 0);

    for (int n = 0; n < 200; n++) begin
      m   = ($urandom_range(0, 7) == 0);
      im  = ($urandom_range(0, 3) == 0);
      op  = 12'($urandom);
      rm  = $urandom;
      cin = 1'($urandom);
      rs  = $urandom & 32'hFFFF_FF00;
      case ($urandom_range(0, 4))
        0:       rs = rs | 32'd0;
        1:       rs = rs | 32'd32;
        2:       rs = rs | 32'd33;
        3:       rs = rs | 32'($urandom_range(0, 40));
        default: rs = rs | 32'($urandom_range(0, 255));
      endcase
      exp = ref_model(m, im, op, rm, rs, cin);
      run_txn($sformatf("rnd%0d", n), m, im, op, rm, rs, cin, exp, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
